// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag indices, FSM states and multiply constants for alu_accumulator
package alu_pkg;
   localparam logic [2:0] OP_LOAD = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_ADC  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_SBC  = 3'b100;
   localparam logic [2:0] OP_AND  = 3'b101;
   localparam logic [2:0] OP_XOR  = 3'b110;
   localparam logic [2:0] OP_MUL  = 3'b111;
   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;
   localparam int MUL_ITERS = 8;
   localparam int CNT_W = $clog2(MUL_ITERS);
   typedef enum logic {
      ST_IDLE,
      ST_MUL_RUN
   } state_t;
endpackage

// File: rtl/alu_accumulator_if.sv
// alu_accumulator_if: request/result bundle between the control unit and the accumulator ALU
interface alu_accumulator_if;
   logic       start;
   logic [2:0] op;
   logic [7:0] operand;
   logic [7:0] acc;
   logic [7:0] acc_hi;
   logic [3:0] flags;
   logic       busy;
   logic       done;
   modport master (output start, op, operand, input acc, acc_hi, flags, busy, done);
   modport slave  (input start, op, operand, output acc, acc_hi, flags, busy, done);
endinterface

// File: rtl/eight_bit_adder.sv
// eight_bit_adder: 8-bit ripple-carry adder with carry-in and carry-out
module eight_bit_adder (
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   input  logic       cin_i,
   output logic [7:0] sum_o,
   output logic       cout_o
);
   logic carry;
   // Ripple the carry bit by bit from the LSB
   always_comb begin
      sum_o = 8'h00;
      carry = cin_i;
      for (int i = 0; i < 8; i++) begin
         sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
         carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
      end
      cout_o = carry;
   end
endmodule

// File: rtl/alu_accumulator.sv
// alu_accumulator: accumulator ALU on one shared adder; shift-add MUL present only when ALU_MUL_EN is defined
module alu_accumulator
   import alu_pkg::*;
(
   input logic              clk,
   input logic              rst,
   alu_accumulator_if.slave bus
);
   logic [7:0] acc_q, acc_d, hi_q, hi_d;
   logic [3:0] flags_q, flags_d;
   logic       done_q, done_d;
   logic [7:0] add_a, add_b, sum, p_hi, mcand;
   logic       add_cin, cout, ovf, run, accept;
`ifdef ALU_MUL_EN
   state_t           state_q, state_d;
   logic [7:0]       mcand_q, mcand_d;
   logic [15:0]      p_q, p_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             last;
   assign run   = state_q == ST_MUL_RUN;
   assign p_hi  = p_q[15:8];
   assign mcand = mcand_q;
   assign last  = cnt_q == CNT_W'(MUL_ITERS - 1);
`else
   assign run   = 1'b0;
   assign p_hi  = 8'h00;
   assign mcand = 8'h00;
`endif
   assign accept  = bus.start && !run;
   assign add_a   = run ? p_hi : acc_q;
   assign add_b   = run ? mcand : (bus.op == OP_SUB || bus.op == OP_SBC) ? ~bus.operand : bus.operand;
   assign add_cin = run ? 1'b0 : (bus.op == OP_SUB) ? 1'b1 :
                    (bus.op == OP_ADC || bus.op == OP_SBC) ? flags_q[FLAG_C] : 1'b0;
   assign ovf     = (add_a[7] == add_b[7]) && (sum[7] != add_a[7]);
   eight_bit_adder u_adder (
      .a_i   (add_a),
      .b_i   (add_b),
      .cin_i (add_cin),
      .sum_o (sum),
      .cout_o(cout)
   );
`ifdef ALU_MUL_EN
   // Multiply FSM: latch operands on MUL start, then add-and-shift once per cycle for MUL_ITERS cycles
   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      p_d     = p_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: if (bus.start && bus.op == OP_MUL) begin
            state_d = ST_MUL_RUN;
            mcand_d = bus.operand;
            p_d     = {8'h00, acc_q};
            cnt_d   = '0;
         end
         ST_MUL_RUN: begin
            p_d     = {(p_q[0] ? {cout, sum} : {1'b0, p_q[15:8]}), p_q[7:1]};
            cnt_d   = cnt_q + 1'b1;
            state_d = last ? ST_IDLE : ST_MUL_RUN;
         end
      endcase
   end
   // Multiply working registers; reset discards any partial product
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         mcand_q <= 8'h00;
         p_q     <= 16'h0000;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         p_q     <= p_d;
         cnt_q   <= cnt_d;
      end
   end
`endif
   // Architectural next state: single-cycle ops on accept, product write-back on the final iteration
   always_comb begin
      acc_d   = acc_q;
      hi_d    = hi_q;
      flags_d = flags_q;
      done_d  = 1'b0;
      if (accept) begin
         done_d = 1'b1;
         case (bus.op)
            OP_LOAD: acc_d = bus.operand;
            OP_AND:  acc_d = acc_q & bus.operand;
            OP_XOR:  acc_d = acc_q ^ bus.operand;
`ifdef ALU_MUL_EN
            OP_MUL:  done_d = 1'b0;
`else
            OP_MUL:  done_d = 1'b1;
`endif
            default: begin
               acc_d           = sum;
               flags_d[FLAG_C] = cout;
               flags_d[FLAG_V] = ovf;
            end
         endcase
         if (bus.op != OP_MUL) begin
            flags_d[FLAG_Z] = acc_d == 8'h00;
            flags_d[FLAG_N] = acc_d[7];
         end
      end
`ifdef ALU_MUL_EN
      if (run && last) begin
         acc_d           = p_d[7:0];
         hi_d            = p_d[15:8];
         flags_d[FLAG_Z] = p_d == 16'h0000;
         flags_d[FLAG_N] = p_d[15];
         flags_d[FLAG_C] = p_d[15:8] != 8'h00;
         flags_d[FLAG_V] = 1'b0;
         done_d          = 1'b1;
      end
`endif
   end
   // Accumulator, high product byte, flags and completion pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q   <= 8'h00;
         hi_q    <= 8'h00;
         flags_q <= 4'h0;
         done_q  <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         hi_q    <= hi_d;
         flags_q <= flags_d;
         done_q  <= done_d;
      end
   end
   assign bus.acc    = acc_q;
   assign bus.acc_hi = hi_q;
   assign bus.flags  = flags_q;
   assign bus.busy   = run;
   assign bus.done   = done_q;
endmodule

// File: tb/tb_alu_accumulator.sv
// tb_alu_accumulator: vector table, hand corner sequences and random ops against an arithmetic reference model
module tb_alu_accumulator;
   import alu_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   alu_accumulator_if bus ();
   alu_accumulator dut (.clk(clk), .rst(rst), .bus(bus));
   int n_vec = 0;
   int n_bad = 0;
   logic [7:0] m_acc = 8'h00, m_hi = 8'h00;
   logic [3:0] m_flags = 4'h0;
   typedef struct {
      logic [2:0] op;
      logic [7:0] b;
      logic [7:0] acc;
      logic [3:0] flags;
   } vec_t;
   vec_t tbl[14];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " acc"}, bus.acc, 0);
      chk({tag, " acc_hi"}, bus.acc_hi, 0);
      chk({tag, " flags"}, bus.flags, 0);
      chk({tag, " busy"}, bus.busy, 0);
      chk({tag, " done"}, bus.done, 0);
   endtask

   task automatic model_reset();
      m_acc = 8'h00;
      m_hi = 8'h00;
      m_flags = 4'h0;
   endtask

   // Reference semantics from plain integer arithmetic
   task automatic model_step(input logic [2:0] op, input logic [7:0] b);
      int a = int'(m_acc);
      int bb = int'(b);
      int sa = int'($signed(m_acc));
      int sb = int'($signed(b));
      int c = int'(m_flags[FLAG_C]);
      int t, s, k;
      case (op)
         OP_LOAD: m_acc = b;
         OP_AND:  m_acc = m_acc & b;
         OP_XOR:  m_acc = m_acc ^ b;
         OP_ADD, OP_ADC: begin
            k = (op == OP_ADC) ? c : 0;
            t = a + bb + k;
            s = sa + sb + k;
            m_acc = t[7:0];
            m_flags[FLAG_C] = t > 255;
            m_flags[FLAG_V] = s > 127 || s < -128;
         end
         OP_SUB, OP_SBC: begin
            k = (op == OP_SUB) ? 0 : 1 - c;
            t = a - bb - k;
            s = sa - sb - k;
            m_acc = t[7:0];
            m_flags[FLAG_C] = t >= 0;
            m_flags[FLAG_V] = s > 127 || s < -128;
         end
         default: begin
`ifdef ALU_MUL_EN
            t = a * bb;
            m_acc = t[7:0];
            m_hi = t[15:8];
            m_flags[FLAG_Z] = t == 0;
            m_flags[FLAG_N] = t[15];
            m_flags[FLAG_C] = t > 255;
            m_flags[FLAG_V] = 1'b0;
`endif
         end
      endcase
      if (op != OP_MUL) begin
         m_flags[FLAG_Z] = m_acc == 8'h00;
         m_flags[FLAG_N] = m_acc[7];
      end
   endtask

   // Present one start for one cycle; returns at the negedge of cycle 1
   task automatic issue(input logic [2:0] op, input logic [7:0] b);
      @(negedge clk);
      chk("done single-cycle", bus.done, 0);
      bus.start = 1'b1;
      bus.op = op;
      bus.operand = b;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic run_op(input logic [2:0] op, input logic [7:0] b, input string tag);
      logic [7:0] pa = m_acc;
      logic [7:0] ph = m_hi;
      logic [3:0] pf = m_flags;
      issue(op, b);
      model_step(op, b);
`ifdef ALU_MUL_EN
      if (op == OP_MUL) begin
         for (int k = 1; k <= MUL_ITERS; k++) begin
            chk({tag, " busy"}, bus.busy, 1);
            chk({tag, " done early"}, bus.done, 0);
            chk({tag, " acc held"}, {bus.acc_hi, bus.acc}, {ph, pa});
            chk({tag, " flags held"}, bus.flags, pf);
            @(negedge clk);
         end
      end
`endif
      chk({tag, " done"}, bus.done, 1);
      chk({tag, " busy idle"}, bus.busy, 0);
      chk({tag, " acc"}, bus.acc, m_acc);
      chk({tag, " acc_hi"}, bus.acc_hi, m_hi);
      chk({tag, " flags"}, bus.flags, m_flags);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running, expected finished");
      $fatal(1);
   end

   initial begin
      logic [3:0] f0;
      bus.start = 1'b0;
      bus.op = 3'b000;
      bus.operand = 8'h00;
      tbl[0]  = '{OP_LOAD, 8'h7F, 8'h7F, 4'h0};
      tbl[1]  = '{OP_ADD,  8'h01, 8'h80, 4'h5};
      tbl[2]  = '{OP_LOAD, 8'h01, 8'h01, 4'h1};
      tbl[3]  = '{OP_ADD,  8'hFF, 8'h00, 4'hA};
      tbl[4]  = '{OP_LOAD, 8'h00, 8'h00, 4'hA};
      tbl[5]  = '{OP_SUB,  8'h01, 8'hFF, 4'h4};
      tbl[6]  = '{OP_SBC,  8'h00, 8'hFE, 4'h6};
      tbl[7]  = '{OP_ADC,  8'h01, 8'h00, 4'hA};
      tbl[8]  = '{OP_XOR,  8'h5A, 8'h5A, 4'h2};
      tbl[9]  = '{OP_AND,  8'h0F, 8'h0A, 4'h2};
      tbl[10] = '{OP_SUB,  8'h0B, 8'hFF, 4'h4};
      tbl[11] = '{OP_LOAD, 8'h80, 8'h80, 4'h4};
      tbl[12] = '{OP_SUB,  8'h01, 8'h7F, 4'h3};
      tbl[13] = '{OP_ADC,  8'h7F, 8'hFF, 4'h5};
      #2;
      chk_zero("power-on reset");
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 14; i++) begin
         run_op(tbl[i].op, tbl[i].b, $sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d const acc", i), bus.acc, tbl[i].acc);
         chk($sformatf("tbl%0d const flags", i), bus.flags, tbl[i].flags);
         chk($sformatf("tbl%0d const acc_hi", i), bus.acc_hi, 0);
      end
      // back-to-back single-cycle ops
      @(negedge clk);
      bus.start = 1'b1;
      bus.op = OP_LOAD;
      bus.operand = 8'h10;
      @(negedge clk);
      model_step(OP_LOAD, 8'h10);
      chk("b2b first done", bus.done, 1);
      chk("b2b first acc", bus.acc, 8'h10);
      bus.op = OP_ADD;
      bus.operand = 8'h20;
      @(negedge clk);
      bus.start = 1'b0;
      model_step(OP_ADD, 8'h20);
      chk("b2b second done", bus.done, 1);
      chk("b2b second acc", bus.acc, 8'h30);
      chk("b2b second flags", bus.flags, m_flags);
      @(negedge clk);
      chk("b2b done drop", bus.done, 0);
`ifdef ALU_MUL_EN
      // 0xFF*0xFF with an ADD offered in cycle 4 that must be dropped
      run_op(OP_LOAD, 8'hFF, "mul pre");
      @(negedge clk);
      bus.start = 1'b1;
      bus.op = OP_MUL;
      bus.operand = 8'hFF;
      @(negedge clk);
      bus.start = 1'b0;
      for (int k = 1; k <= MUL_ITERS; k++) begin
         chk($sformatf("mulff busy c%0d", k), bus.busy, 1);
         chk($sformatf("mulff done c%0d", k), bus.done, 0);
         chk($sformatf("mulff acc c%0d", k), bus.acc, 8'hFF);
         if (k == 4) begin
            bus.start = 1'b1;
            bus.op = OP_ADD;
            bus.operand = 8'h05;
         end else
            bus.start = 1'b0;
         @(negedge clk);
      end
      bus.start = 1'b0;
      chk("mulff done", bus.done, 1);
      chk("mulff busy", bus.busy, 0);
      chk("mulff acc_hi", bus.acc_hi, 8'hFE);
      chk("mulff acc", bus.acc, 8'h01);
      chk("mulff flags", bus.flags, 4'h6);
      model_step(OP_MUL, 8'hFF);
      @(negedge clk);
      chk("mulff no queued add done", bus.done, 0);
      chk("mulff no queued add acc", bus.acc, 8'h01);
`else
      run_op(OP_LOAD, 8'h12, "nop pre");
      f0 = m_flags;
      run_op(OP_MUL, 8'h34, "nop mul");
      chk("nop acc", bus.acc, 8'h12);
      chk("nop acc_hi", bus.acc_hi, 8'h00);
      chk("nop flags", bus.flags, f0);
`endif
      // reset asserted in cycle 4 of a multiply
      run_op(OP_LOAD, 8'h0C, "rst pre");
      @(negedge clk);
      bus.start = 1'b1;
      bus.op = OP_MUL;
      bus.operand = 8'h0A;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk_zero("mid-mul reset");
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int k = 0; k < 10; k++) begin
         chk("post-reset done", bus.done, 0);
         chk("post-reset busy", bus.busy, 0);
         @(negedge clk);
      end
      run_op(OP_LOAD, 8'h03, "rst post load");
      run_op(OP_MUL, 8'h05, "rst post mul");
`ifdef ALU_MUL_EN
      chk("3x5 acc", bus.acc, 8'h0F);
      chk("3x5 acc_hi", bus.acc_hi, 8'h00);
      chk("3x5 C", bus.flags[FLAG_C], 0);
`else
      chk("3 nop acc", bus.acc, 8'h03);
      chk("3 nop acc_hi", bus.acc_hi, 8'h00);
`endif
      for (int i = 0; i < 150; i++) begin
         logic [2:0] op = 3'($urandom_range(0, 7));
         logic [7:0] b = 8'($urandom);
         run_op(op, b, $sformatf("rnd%0d op%0d b%h", i, op, b));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
